// File: rtl/tm_l1_miss_sched_pkg.sv
// Shared types for the L1 timing-model miss scheduler: per-thread miss state,
// memory transaction record, clock bundle and widths.
package libtm_cache;

  localparam int TM_NTHREADS     = 64;
  localparam int TM_TIDW         = 6;
  localparam int NPARTITIONIDMSB = 3;
  localparam int TM_PIDW         = NPARTITIONIDMSB + 1;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef enum logic [2:0] {
    MS_IDLE      = 3'd0,
    MS_WB_PEND   = 3'd1,
    MS_WB_WAIT   = 3'd2,
    MS_FILL_PEND = 3'd3,
    MS_FILL_WAIT = 3'd4
  } miss_state_t;

  typedef struct packed {
    logic [TM_TIDW-1:0] tid;
    logic [31:0]        addr;
    logic               write;
    logic [TM_PIDW-1:0] partition;
  } tm_miss_req_t;

  function automatic logic is_pending(miss_state_t s);
    return (s == MS_WB_PEND) || (s == MS_FILL_PEND);
  endfunction

  function automatic logic is_waiting(miss_state_t s);
    return (s == MS_WB_WAIT) || (s == MS_FILL_WAIT);
  endfunction

endpackage

// File: rtl/tm_l1_miss_sched_if.sv
// Valid/ready request channel plus completion channel between the miss
// scheduler (master) and the shared L2/DRAM timing model (slave).
interface tm_l1_miss_sched_if import libtm_cache::*; #(
  parameter int TIDW = TM_TIDW,
  parameter int PIDW = TM_PIDW
) ();

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [TIDW-1:0] mem_req_tid;
  logic [31:0]     mem_req_addr;
  logic            mem_req_write;
  logic [PIDW-1:0] mem_req_partition;
  logic            mem_resp_valid;
  logic [TIDW-1:0] mem_resp_tid;

  modport master (
    output mem_req_valid, mem_req_tid, mem_req_addr, mem_req_write, mem_req_partition,
    input  mem_req_ready, mem_resp_valid, mem_resp_tid
  );

  modport slave (
    input  mem_req_valid, mem_req_tid, mem_req_addr, mem_req_write, mem_req_partition,
    output mem_req_ready, mem_resp_valid, mem_resp_tid
  );

endinterface

// File: rtl/tm_l1_miss_sched_rr_pick.sv
// Round-robin picker: lowest eligible index at or above ptr, otherwise the
// lowest eligible index overall (wrap-around pass).
module tm_rr_pick #(
  parameter int NTHREADS = 64,
  parameter int TIDW     = 6
) (
  input  logic [NTHREADS-1:0] eligible,
  input  logic [TIDW-1:0]     ptr,
  output logic                found,
  output logic [TIDW-1:0]     winner
);

  logic [NTHREADS-1:0] upper;
  logic                upper_found;
  logic                any_found;
  logic [TIDW-1:0]     upper_idx;
  logic [TIDW-1:0]     any_idx;

  // Scanning downward and overwriting leaves the lowest set index in each pass.
  always_comb begin
    upper       = '0;
    upper_found = 1'b0;
    any_found   = 1'b0;
    upper_idx   = '0;
    any_idx     = '0;
    for (int i = 0; i < NTHREADS; i++) begin
      upper[i] = eligible[i] && (i >= int'(ptr));
    end
    for (int i = NTHREADS - 1; i >= 0; i--) begin
      if (upper[i]) begin
        upper_found = 1'b1;
        upper_idx   = TIDW'(i);
      end
      if (eligible[i]) begin
        any_found = 1'b1;
        any_idx   = TIDW'(i);
      end
    end
    found  = any_found;
    winner = upper_found ? upper_idx : any_idx;
  end

endmodule

// File: rtl/tm_l1_miss_sched.sv
// Per-thread L1 miss scheduler: tracks one miss per thread (optional writeback
// then fill) and round-robins pending transactions onto one memory port.
module tm_l1_miss_sched import libtm_cache::*; #(
  parameter int NTHREADS = TM_NTHREADS,
  parameter int TIDW     = $clog2(NTHREADS),
  parameter int PIDW     = TM_PIDW
) (
  input  iu_clk_type          gclk,
  input  logic                rst,
  input  logic                run,
  input  logic                req_valid,
  input  logic [TIDW-1:0]     req_tid,
  input  logic [31:0]         req_addr,
  input  logic                req_wb_valid,
  input  logic [31:0]         req_wb_addr,
  input  logic [PIDW-1:0]     req_partition,
  tm_l1_miss_sched_if.master  mem,
  input  logic [TIDW-1:0]     query_tid,
  output logic                query_stall,
  output logic [NTHREADS-1:0] thread_busy,
  output logic [TIDW:0]       pending_cnt,
  output logic                protocol_err
);

  logic clk;
  assign clk = gclk.clk;

  miss_state_t     state_q   [NTHREADS];
  miss_state_t     state_d   [NTHREADS];
  logic [31:0]     fill_addr_q [NTHREADS];
  logic [31:0]     wb_addr_q   [NTHREADS];
  logic [PIDW-1:0] part_q      [NTHREADS];

  tm_miss_req_t    slot_q, slot_d;
  logic            slot_valid_q, slot_valid_d;
  logic [TIDW-1:0] rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;
  logic [TIDW:0]   pending_cnt_q, pending_cnt_d;

  logic [NTHREADS-1:0] eligible;
  logic [NTHREADS-1:0] busy_d;
  logic                pick_found;
  logic [TIDW-1:0]     pick_idx;
  logic                handshake;
  logic                load;
  logic                accept;
  logic                acc_err;
  logic                resp_err;

  always_comb begin
    for (int i = 0; i < NTHREADS; i++) begin
      eligible[i]    = is_pending(state_q[i]);
      thread_busy[i] = (state_q[i] != MS_IDLE);
    end
  end

  tm_rr_pick #(
    .NTHREADS (NTHREADS),
    .TIDW     (TIDW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .found    (pick_found),
    .winner   (pick_idx)
  );

  // Request legality is judged on the registered state, before any response
  // landing in the same cycle, so a request racing its own completion is dropped.
  always_comb begin
    handshake = slot_valid_q & mem.mem_req_ready;
    load      = (~slot_valid_q | handshake) & run & pick_found;
    accept    = req_valid & (state_q[req_tid] == MS_IDLE);
    acc_err   = req_valid & ~accept;
    resp_err  = mem.mem_resp_valid & ~is_waiting(state_q[mem.mem_resp_tid]);
  end

  // Response, load and accept can only ever hit distinct threads legally
  // (WAIT, PEND and IDLE respectively), so applying them in sequence is safe.
  always_comb begin
    for (int i = 0; i < NTHREADS; i++) begin
      state_d[i] = state_q[i];
    end
    if (mem.mem_resp_valid) begin
      case (state_q[mem.mem_resp_tid])
        MS_WB_WAIT:   state_d[mem.mem_resp_tid] = MS_FILL_PEND;
        MS_FILL_WAIT: state_d[mem.mem_resp_tid] = MS_IDLE;
        default:      ;
      endcase
    end
    if (load) begin
      state_d[pick_idx] = (state_q[pick_idx] == MS_WB_PEND) ? MS_WB_WAIT : MS_FILL_WAIT;
    end
    if (accept) begin
      state_d[req_tid] = req_wb_valid ? MS_WB_PEND : MS_FILL_PEND;
    end
  end

  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    rr_ptr_d     = rr_ptr_q;
    if (load) begin
      slot_valid_d     = 1'b1;
      slot_d.tid       = TM_TIDW'(pick_idx);
      slot_d.write     = (state_q[pick_idx] == MS_WB_PEND);
      slot_d.addr      = slot_d.write ? wb_addr_q[pick_idx] : fill_addr_q[pick_idx];
      slot_d.partition = TM_PIDW'(part_q[pick_idx]);
      rr_ptr_d         = pick_idx + TIDW'(1);
    end else if (handshake) begin
      slot_valid_d = 1'b0;
      slot_d       = '0;
    end
  end

  always_comb begin
    err_d         = err_q | acc_err | resp_err;
    pending_cnt_d = '0;
    for (int i = 0; i < NTHREADS; i++) begin
      busy_d[i]     = (state_d[i] != MS_IDLE);
      pending_cnt_d = pending_cnt_d + {{TIDW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NTHREADS; i++) begin
        state_q[i] <= MS_IDLE;
      end
      slot_q        <= '0;
      slot_valid_q  <= 1'b0;
      rr_ptr_q      <= '0;
      err_q         <= 1'b0;
      pending_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NTHREADS; i++) begin
        state_q[i] <= state_d[i];
      end
      slot_q        <= slot_d;
      slot_valid_q  <= slot_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      err_q         <= err_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  // Per-thread payload only changes on accept; the state machine guards its use.
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      fill_addr_q[req_tid] <= req_addr;
      wb_addr_q[req_tid]   <= req_wb_addr;
      part_q[req_tid]      <= req_partition;
    end
  end

  always_comb begin
    mem.mem_req_valid     = slot_valid_q;
    mem.mem_req_tid       = TIDW'(slot_q.tid);
    mem.mem_req_addr      = slot_q.addr;
    mem.mem_req_write     = slot_q.write;
    mem.mem_req_partition = PIDW'(slot_q.partition);
    query_stall           = thread_busy[query_tid] | (req_valid & (req_tid == query_tid));
    pending_cnt           = pending_cnt_q;
    protocol_err          = err_q;
  end

endmodule

// File: tb/tb_tm_l1_miss_sched.sv
// Bench for tm_l1_miss_sched: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the scheduler.
module tb_tm_l1_miss_sched;
  import libtm_cache::*;

  localparam int NT = 64;
  localparam int TW = 6;
  localparam int PW = TM_PIDW;

  logic          clk;
  iu_clk_type    gclk;
  logic          rst, run, req_valid, req_wb_valid;
  logic [TW-1:0] req_tid, query_tid;
  logic [31:0]   req_addr, req_wb_addr;
  logic [PW-1:0] req_partition;
  logic          query_stall;
  logic [NT-1:0] thread_busy;
  logic [TW:0]   pending_cnt;
  logic          protocol_err;

  tm_l1_miss_sched_if #(.TIDW(TW), .PIDW(PW)) mif ();

  tm_l1_miss_sched #(.NTHREADS(NT), .TIDW(TW), .PIDW(PW)) dut (
    .gclk(gclk), .rst(rst), .run(run),
    .req_valid(req_valid), .req_tid(req_tid), .req_addr(req_addr),
    .req_wb_valid(req_wb_valid), .req_wb_addr(req_wb_addr), .req_partition(req_partition),
    .mem(mif), .query_tid(query_tid), .query_stall(query_stall),
    .thread_busy(thread_busy), .pending_cnt(pending_cnt), .protocol_err(protocol_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always_comb gclk.clk = clk;

  // Transaction-level model: a thread is busy until its fill completes; it is
  // pending whenever busy and not in flight; wb_left marks an unfinished writeback.
  bit            m_busy [NT];
  bit            m_fly  [NT];
  bit            m_wbl  [NT];
  logic [31:0]   m_fill [NT];
  logic [31:0]   m_wba  [NT];
  logic [PW-1:0] m_part [NT];
  bit            m_sv, m_swr, m_err;
  logic [TW-1:0] m_stid;
  logic [31:0]   m_saddr;
  logic [PW-1:0] m_spart;
  int            m_ptr;
  int            n_cmp, n_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT-1:0] model_busy();
    logic [NT-1:0] v;
    for (int t = 0; t < NT; t++) v[t] = m_busy[t];
    return v;
  endfunction

  task automatic model_step();
    int  w;
    bit  hs, acc;
    int  r;
    if (!rst) begin
      for (int t = 0; t < NT; t++) begin
        m_busy[t] = 0; m_fly[t] = 0; m_wbl[t] = 0;
      end
      m_sv = 0; m_swr = 0; m_err = 0; m_stid = '0; m_saddr = '0; m_spart = '0; m_ptr = 0;
      return;
    end
    hs = m_sv && mif.mem_req_ready;
    w  = -1;
    if ((!m_sv || hs) && run) begin
      for (int k = 0; k < NT; k++) begin
        int t;
        t = (m_ptr + k) % NT;
        if (m_busy[t] && !m_fly[t]) begin
          w = t;
          break;
        end
      end
    end
    acc = req_valid && !m_busy[req_tid];
    if (req_valid && !acc) m_err = 1;
    if (mif.mem_resp_valid) begin
      r = int'(mif.mem_resp_tid);
      if (m_busy[r] && m_fly[r]) begin
        m_fly[r] = 0;
        if (m_wbl[r]) m_wbl[r] = 0;
        else m_busy[r] = 0;
      end else begin
        m_err = 1;
      end
    end
    if (w >= 0) begin
      m_sv    = 1;
      m_stid  = TW'(w);
      m_swr   = m_wbl[w];
      m_saddr = m_swr ? m_wba[w] : m_fill[w];
      m_spart = m_part[w];
      m_fly[w] = 1;
      m_ptr   = (w + 1) % NT;
    end else if (hs) begin
      m_sv = 0;
    end
    if (acc) begin
      m_busy[req_tid] = 1;
      m_fly[req_tid]  = 0;
      m_wbl[req_tid]  = req_wb_valid;
      m_fill[req_tid] = req_addr;
      m_wba[req_tid]  = req_wb_addr;
      m_part[req_tid] = req_partition;
    end
  endtask

  task automatic check_outputs();
    check("mem_req_valid", 64'(mif.mem_req_valid), 64'(m_sv));
    if (m_sv) begin
      check("mem_req_tid", 64'(mif.mem_req_tid), 64'(m_stid));
      check("mem_req_addr", 64'(mif.mem_req_addr), 64'(m_saddr));
      check("mem_req_write", 64'(mif.mem_req_write), 64'(m_swr));
      check("mem_req_partition", 64'(mif.mem_req_partition), 64'(m_spart));
    end
    check("thread_busy", 64'(thread_busy), 64'(model_busy()));
    check("pending_cnt", 64'(pending_cnt), 64'($countones(model_busy())));
    check("protocol_err", 64'(protocol_err), 64'(m_err));
  endtask

  // Inputs are already applied; check the combinational stall, step the model,
  // clock the DUT and compare the registered outputs just after the edge.
  task automatic cycle();
    #1;
    if (rst) check("query_stall", 64'(query_stall),
                   64'(m_busy[query_tid] || (req_valid && req_tid == query_tid)));
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_req(input int tid, input logic [31:0] a, input bit wb,
                         input logic [31:0] wa, input int part);
    req_valid     = 1'b1;
    req_tid       = TW'(tid);
    req_addr      = a;
    req_wb_valid  = wb;
    req_wb_addr   = wa;
    req_partition = PW'(part);
  endtask

  task automatic set_resp(input int tid);
    mif.mem_resp_valid = 1'b1;
    mif.mem_resp_tid   = TW'(tid);
  endtask

  task automatic idle();
    req_valid          = 1'b0;
    mif.mem_resp_valid = 1'b0;
  endtask

  logic [TW-1:0] g [3];

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; run = 1'b1; query_tid = '0;
    req_valid = 0; req_tid = '0; req_addr = '0; req_wb_valid = 0; req_wb_addr = '0; req_partition = '0;
    mif.mem_req_ready = 1'b1; mif.mem_resp_valid = 1'b0; mif.mem_resp_tid = '0;

    // Reset and first-miss latency
    cycle();
    rst = 1'b1;
    check("rst_tid", 64'(mif.mem_req_tid), 64'(0));
    check("rst_addr", 64'(mif.mem_req_addr), 64'(0));
    check("rst_write", 64'(mif.mem_req_write), 64'(0));
    check("rst_part", 64'(mif.mem_req_partition), 64'(0));
    set_req(3, 32'h1000, 0, 32'h0, 2); query_tid = 3;
    cycle(); idle();
    check("lat_t1_valid", 64'(mif.mem_req_valid), 64'(0));
    cycle();
    check("lat_t2_valid", 64'(mif.mem_req_valid), 64'(1));
    check("lat_t2_tid", 64'(mif.mem_req_tid), 64'(3));
    check("lat_t2_addr", 64'(mif.mem_req_addr), 64'(32'h1000));
    check("lat_t2_write", 64'(mif.mem_req_write), 64'(0));
    check("cnt_one", 64'(pending_cnt), 64'(1));
    cycle();
    set_resp(3); cycle(); idle();
    check("busy3_clear", 64'(thread_busy[3]), 64'(0));
    check("cnt_zero", 64'(pending_cnt), 64'(0));

    // Writeback then fill for thread 5
    set_req(5, 32'h3000, 1, 32'h2040, 1); query_tid = 5;
    cycle(); idle();
    check("stall5_a", 64'(query_stall), 64'(1));
    cycle();
    check("wb_write", 64'(mif.mem_req_write), 64'(1));
    check("wb_addr", 64'(mif.mem_req_addr), 64'(32'h2040));
    cycle();
    set_resp(5); cycle(); idle();
    check("stall5_b", 64'(query_stall), 64'(1));
    cycle();
    check("fill_write", 64'(mif.mem_req_write), 64'(0));
    check("fill_addr", 64'(mif.mem_req_addr), 64'(32'h3000));
    cycle();
    set_resp(5); cycle(); idle();
    check("stall5_done", 64'(query_stall), 64'(0));

    // Round-robin order starting from rr_ptr = 3
    set_req(2, 32'h7000, 0, 32'h0, 0); cycle(); idle();
    cycle(); cycle();
    set_resp(2); cycle(); idle();
    run = 1'b0;
    set_req(0, 32'h0100, 0, 32'h0, 0); cycle();
    set_req(7, 32'h0700, 0, 32'h0, 0); cycle();
    set_req(2, 32'h0200, 0, 32'h0, 0); cycle(); idle();
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      g[i] = mif.mem_req_tid;
    end
    check("rr_first", 64'(g[0]), 64'(7));
    check("rr_second", 64'(g[1]), 64'(0));
    check("rr_third", 64'(g[2]), 64'(2));
    set_resp(7); cycle();
    set_resp(0); cycle();
    set_resp(2); cycle(); idle();
    run = 1'b0;
    set_req(1, 32'h0111, 0, 32'h0, 0); cycle();
    set_req(4, 32'h0444, 0, 32'h0, 0); cycle(); idle();
    run = 1'b1;
    cycle();
    check("rr_ptr3_a", 64'(mif.mem_req_tid), 64'(4));
    cycle();
    check("rr_ptr3_b", 64'(mif.mem_req_tid), 64'(1));
    cycle();
    set_resp(4); cycle();
    set_resp(1); cycle(); idle();

    // Backpressure hold, then run=0 still lets responses complete
    mif.mem_req_ready = 1'b0;
    set_req(1, 32'h4440, 0, 32'h0, 3); cycle(); idle();
    cycle();
    run = 1'b0;
    set_req(9, 32'h9000, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(); idle();
      check("hold_valid", 64'(mif.mem_req_valid), 64'(1));
      check("hold_tid", 64'(mif.mem_req_tid), 64'(1));
      check("hold_addr", 64'(mif.mem_req_addr), 64'(32'h4440));
    end
    mif.mem_req_ready = 1'b1;
    cycle();
    check("run0_no_load", 64'(mif.mem_req_valid), 64'(0));
    set_resp(1); cycle(); idle();
    check("run0_resp", 64'(thread_busy[1]), 64'(0));
    run = 1'b1;
    cycle();
    check("run1_load9", 64'(mif.mem_req_tid), 64'(9));
    cycle();
    set_resp(9); cycle(); idle();

    // Protocol errors
    set_resp(6); cycle(); idle();
    check("err_resp_idle", 64'(protocol_err), 64'(1));
    cycle();
    check("err_sticky", 64'(protocol_err), 64'(1));
    rst = 1'b0; cycle(); rst = 1'b1;
    check("err_cleared", 64'(protocol_err), 64'(0));
    run = 1'b0;
    set_req(4, 32'h5000, 0, 32'h0, 1); cycle();
    set_req(4, 32'h6000, 1, 32'h6040, 2); cycle(); idle();
    check("err_dup_req", 64'(protocol_err), 64'(1));
    run = 1'b1;
    cycle();
    check("dup_keep_addr", 64'(mif.mem_req_addr), 64'(32'h5000));
    check("dup_keep_write", 64'(mif.mem_req_write), 64'(0));
    cycle();
    set_resp(4); cycle(); idle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int pick, start;
      idle();
      run = ($urandom_range(0, 9) != 0);
      mif.mem_req_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) begin
        int tid;
        tid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NT - 1)) : int'($urandom_range(0, 7));
        set_req(tid, $urandom, $urandom_range(0, 1) == 1, $urandom, int'($urandom_range(0, 15)));
      end
      query_tid = ($urandom_range(0, 1) == 1) ? req_tid : TW'($urandom_range(0, 7));
      pick = -1;
      if ($urandom_range(0, 9) < 4) begin
        start = int'($urandom_range(0, NT - 1));
        for (int k = 0; k < NT; k++) begin
          int t;
          t = (start + k) % NT;
          if (m_fly[t] && !(m_sv && int'(m_stid) == t && !mif.mem_req_ready)) begin
            pick = t;
            break;
          end
        end
      end else if ($urandom_range(0, 99) < 3) begin
        pick = int'($urandom_range(0, NT - 1));
      end
      if (pick >= 0) set_resp(pick);
      cycle();
    end
    idle();

    // Reset in the middle of traffic
    run = 1'b1;
    rst = 1'b0; cycle(); rst = 1'b1;
    mif.mem_req_ready = 1'b0;
    set_req(10, 32'hA000, 1, 32'hA040, 5); cycle();
    set_req(11, 32'hB000, 0, 32'h0, 6); cycle(); idle();
    cycle();
    check("pre_rst_full", 64'(mif.mem_req_valid), 64'(1));
    check("pre_rst_wb", 64'(mif.mem_req_write), 64'(1));
    rst = 1'b0; cycle();
    check("rst_mid_valid", 64'(mif.mem_req_valid), 64'(0));
    check("rst_mid_tid", 64'(mif.mem_req_tid), 64'(0));
    check("rst_mid_addr", 64'(mif.mem_req_addr), 64'(0));
    check("rst_mid_write", 64'(mif.mem_req_write), 64'(0));
    check("rst_mid_part", 64'(mif.mem_req_partition), 64'(0));
    check("rst_mid_busy", 64'(thread_busy), 64'(0));
    check("rst_mid_cnt", 64'(pending_cnt), 64'(0));
    rst = 1'b1; mif.mem_req_ready = 1'b1;
    cycle();
    check("post_rst_valid", 64'(mif.mem_req_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tm_l1_miss_sched.md
Name: tm_l1_miss_sched

Overview:
- Per-thread miss scheduler between the L1 timing model and the shared L2/DRAM timing port.
- Accepts at most one outstanding L1 miss per thread from the TM pipe, optionally preceded by a dirty writeback.
- Sequences each miss as a writeback transaction, then a fill transaction.
- Round-robins all pending transactions onto one valid/ready memory port and reports per-thread stall status to the L1 stage.

Parameters:
NTHREADS, 64, number of hardware threads tracked (power of two)
TIDW, 6, thread-id width = log2(NTHREADS)
PIDW, NPARTITIONIDMSB+1, partition-id width

Ports:
gclk  in  iu_clk_type  clock; all state on gclk.clk rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
run  in  1  when 0, no new transaction loaded into output slot; responses still accepted
req_valid  in  1  new miss from TM pipe stage 3
req_tid  in  TIDW  requesting thread
req_addr  in  32  fill line address (tag-masked)
req_wb_valid  in  1  dirty victim must be written back first
req_wb_addr  in  32  victim line address
req_partition  in  PIDW  partition id of requester
mem_req_valid  out  1  transaction offered to memory model
mem_req_ready  in  1  memory model accepts
mem_req_tid  out  TIDW  owning thread
mem_req_addr  out  32  line address
mem_req_write  out  1  1 = writeback, 0 = fill
mem_req_partition  out  PIDW  partition id
mem_resp_valid  in  1  transaction completion
mem_resp_tid  in  TIDW  completing thread
query_tid  in  TIDW  thread being checked by L1 stage
query_stall  out  1  thread must stay stalled
thread_busy  out  NTHREADS  bit per thread, 1 = not IDLE
pending_cnt  out  TIDW+1  number of non-IDLE threads
protocol_err  out  1  sticky protocol violation flag

Behaviour:
- Per-thread state: IDLE, WB_PEND, WB_WAIT, FILL_PEND, FILL_WAIT. Per-thread registers: fill addr, wb addr, partition.
- Accept rule: req_valid with thread IDLE loads addresses and partition.
  - Next state is WB_PEND if req_wb_valid, else FILL_PEND.
  - req_valid to a non-IDLE thread: request dropped, protocol_err set.
- Output slot is registered and holds at most 1 transaction.
  - Slot loads when (slot empty or mem_req_valid&mem_req_ready) and run=1 and any thread is in WB_PEND/FILL_PEND.
  - Winner is the first pending thread at or after rr_ptr, modulo NTHREADS.
  - On load, winner moves *_PEND -> *_WAIT and rr_ptr <= winner+1 (wraps NTHREADS-1 -> 0).
  - mem_req_write = 1 for a WB_PEND winner; address comes from the wb or fill register accordingly.
- Slot outputs hold stable while mem_req_valid & ~mem_req_ready.
  - Handshake with no eligible winner (or run=0) clears mem_req_valid.
- Latency: req accepted in cycle t -> mem_req_valid earliest in cycle t+2 (thread visible in t+1, slot loaded at end of t+1).
- Responses:
  - mem_resp_valid in WB_WAIT -> FILL_PEND.
  - In FILL_WAIT -> IDLE.
  - In any other state: ignored, protocol_err set.
  - A response may arrive in the same cycle as the handshake of its own transaction; the WAIT transition takes effect, and the response is legal.
- Simultaneous events in one cycle:
  - Response for X plus new req for X: response processed; req checked against the pre-response state, so it is an error and dropped.
  - Response plus load plus accept for three different threads: all take effect.
- query_stall = thread_busy[query_tid] | (req_valid & req_tid==query_tid). This path is combinational.
- pending_cnt = popcount(thread_busy), registered, in range 0..NTHREADS.
- Reset (rst=0) from any state, including mid-transaction:
  - All threads IDLE, slot empty, rr_ptr=0.
  - mem_req_valid=0, mem_req_tid/addr/write/partition=0.
  - thread_busy=0, pending_cnt=0, protocol_err=0.
  - Responses arriving after reset are ignored.

Decomposition:
- libtm_cache:
  - miss_state_t enum (3 bits).
  - tm_miss_req_t struct {tid, addr, write, partition}, used for the slot and the port bundle.
- Sub-module tm_rr_pick: NTHREADS-bit eligible vector plus pointer in -> found flag and winner index out. Purely combinational, two-pass priority (upper half from ptr, then wrap).

Test Plan:
- Reset, req tid=3 addr=0x1000 no wb, ready=1 -> mem_req_valid at t+2: tid 3, addr 0x1000, write 0; resp tid 3 -> thread_busy[3]=0, pending_cnt 1->0.
- req tid=5 wb addr 0x2040, fill 0x3000 -> writeback transaction (write 1, addr 0x2040) first; after resp, fill transaction (write 0, addr 0x3000); query_stall(5)=1 throughout until final resp.
- Threads 0, 2, 7 pending with rr_ptr=3, ready=1 -> grant order 7, 0, 2; rr_ptr finishes at 3.
- ready=0 for 4 cycles with tid 1 in slot -> outputs stable; run=0 -> no new load, but resp tid 1 still returns it to IDLE.
- Protocol errors: req tid 4 twice before resp, or resp tid 6 while IDLE -> protocol_err=1 sticky; thread 4 state unchanged.
- Reset asserted while threads are in WB_WAIT and FILL_PEND and the slot is full -> next cycle all outputs 0, pending_cnt=0.
